// File: rtl/bitonic_topk_stream_if.sv
// Streaming handshake bundle for bitonic_topk_stream: one vector in, the
// top-K ranked values and their original lane indices out.
interface bitonic_topk_stream_if #(
    parameter int DATAWIDTH  = 8,
    parameter int DATALENGTH = 16,
    parameter int TOPK       = 4
);
    localparam int L  = $clog2(DATALENGTH);
    localparam int IW = (L > 1) ? L : 1;
    localparam int S  = L * (L + 1) / 2;
    localparam int CW = $clog2(S + 1);

    logic                 flush_i;
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic                 desc_i;
    logic [DATAWIDTH-1:0] x_i [DATALENGTH];
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [DATAWIDTH-1:0] y_o [TOPK];
    logic [IW-1:0]        idx_o [TOPK];
    logic [CW-1:0]        inflight_o;

    modport master (output flush_i, in_valid_i, desc_i, x_i, out_ready_i,
                    input  in_ready_o, out_valid_o, y_o, idx_o, inflight_o);
    modport slave  (input  flush_i, in_valid_i, desc_i, x_i, out_ready_i,
                    output in_ready_o, out_valid_o, y_o, idx_o, inflight_o);
endinterface

// File: rtl/bitonic_topk_stream.sv
// Pipelined bitonic sorter over (value, lane index) keys with per-vector
// direction; emits the TOPK best lanes under a global stall-on-backpressure.
module bitonic_topk_stream #(
    parameter int DATAWIDTH  = 8,
    parameter int DATALENGTH = 16,
    parameter int TOPK       = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    bitonic_topk_stream_if.slave bus
);
    localparam int DW = DATAWIDTH;
    localparam int DL = DATALENGTH;
    localparam int L  = $clog2(DL);
    localparam int IW = (L > 1) ? L : 1;
    localparam int S  = L * (L + 1) / 2;
    localparam int CW = $clog2(S + 1);

    // Block size K and partner distance J of compare column t, in network order.
    function automatic int col_k(input int t);
        int n;
        int r;
        n = 0;
        r = 2;
        for (int p = 1; p <= L; p++)
            for (int q = p - 1; q >= 0; q--) begin
                if (n == t) r = 1 << p;
                n++;
            end
        return r;
    endfunction

    function automatic int col_j(input int t);
        int n;
        int r;
        n = 0;
        r = 1;
        for (int p = 1; p <= L; p++)
            for (int q = p - 1; q >= 0; q--) begin
                if (n == t) r = 1 << q;
                n++;
            end
        return r;
    endfunction

    // Strict total order: value by direction, then lower lane index first.
    function automatic logic better(input logic [DW-1:0] av, input logic [IW-1:0] ai,
                                    input logic [DW-1:0] bv, input logic [IW-1:0] bi,
                                    input logic d);
        if (av == bv) return ai < bi;
        return d ? (av > bv) : (av < bv);
    endfunction

    logic [S:0]                    vld, vld_nxt;
    logic [S-1:0]                  dsc;
    logic [S-1:0][DL-1:0][DW-1:0]  val;
    logic [S-1:0][DL-1:0][IW-1:0]  idx;
    logic [S:1][DL-1:0][DW-1:0]    nval;
    logic [S:1][DL-1:0][IW-1:0]    nidx;
    logic [TOPK-1:0][DW-1:0]       yq;
    logic [TOPK-1:0][IW-1:0]       iq;
    logic [CW-1:0]                 cnt, cnt_nxt;
    logic                          adv;

    assign adv             = bus.out_ready_i | ~vld[S];
    assign bus.in_ready_o  = adv;
    assign bus.out_valid_o = vld[S];
    assign bus.inflight_o  = cnt;

    for (genvar k = 0; k < TOPK; k++) begin : g_out
        assign bus.y_o[k]   = yq[k];
        assign bus.idx_o[k] = iq[k];
    end

    // Column c sorts stage c-1; a lane keeps its own key when the pair is
    // already in the block's order, else takes its partner's.
    for (genvar c = 1; c <= S; c++) begin : g_col
        localparam int K = col_k(c - 1);
        localparam int J = col_j(c - 1);
        for (genvar i = 0; i < DL; i++) begin : g_lane
            localparam int P  = i ^ J;
            localparam int LO = (i < P) ? i : P;
            localparam int HI = (i < P) ? P : i;
            localparam bit UP = ((LO & K) == 0);
            logic keep;
            assign keep = (UP == better(val[c-1][LO], idx[c-1][LO],
                                        val[c-1][HI], idx[c-1][HI], dsc[c-1]));
            assign nval[c][i] = keep ? val[c-1][i] : val[c-1][P];
            assign nidx[c][i] = keep ? idx[c-1][i] : idx[c-1][P];
        end
    end

    if (TOPK < DL) begin : g_drop
        logic unused_lanes;
        assign unused_lanes = ^{nval[S][DL-1:TOPK], nidx[S][DL-1:TOPK]};
    end

    // Occupancy counts the S compare-column registers, not the capture stage.
    always_comb begin
        vld_nxt = vld;
        if (bus.flush_i)
            vld_nxt = '0;
        else if (adv)
            vld_nxt = {vld[S-1:0], bus.in_valid_i};
        cnt_nxt = '0;
        for (int c = 1; c <= S; c++)
            cnt_nxt = cnt_nxt + CW'(vld_nxt[c]);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld <= '0;
            cnt <= '0;
            dsc <= '0;
            val <= '0;
            idx <= '0;
            yq  <= '0;
            iq  <= '0;
        end else begin
            vld <= vld_nxt;
            cnt <= cnt_nxt;
            if (adv) begin
                for (int i = 0; i < DL; i++) begin
                    val[0][i] <= bus.x_i[i];
                    idx[0][i] <= IW'(i);
                end
                dsc[0] <= bus.desc_i;
                for (int c = 1; c < S; c++) begin
                    val[c] <= nval[c];
                    idx[c] <= nidx[c];
                    dsc[c] <= dsc[c-1];
                end
                for (int k = 0; k < TOPK; k++) begin
                    yq[k] <= nval[S][k];
                    iq[k] <= nidx[S][k];
                end
            end
        end
    end
endmodule

// File: tb/tb_bitonic_topk_stream.sv
// Randomised bench for bitonic_topk_stream against a rank-by-selection
// reference model, plus directed ordering, tie, flush and reset cases.
module tb_bitonic_topk_stream;
    localparam int DW = 8;
    localparam int DL = 16;
    localparam int TK = 4;
    localparam int S  = 10;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   tests = 0;
    int   fails = 0;

    bitonic_topk_stream_if #(.DATAWIDTH(DW), .DATALENGTH(DL), .TOPK(TK)) bus ();
    bitonic_topk_stream #(.DATAWIDTH(DW), .DATALENGTH(DL), .TOPK(TK)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .bus(bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ranks_before(input int a, input int ia, input int b, input int ib,
                                        input bit d);
        if (a == b) return ia < ib;
        return d ? (a > b) : (a < b);
    endfunction

    // Model: S+1 slots that shift together whenever the output is free.
    bit mv  [0:S];
    int mid [0:S];
    int ey  [0:1023][0:TK-1];
    int ei  [0:1023][0:TK-1];
    int nvec = 0;

    always @(posedge clk_i or posedge rst_i) begin : model
        bit madv;
        bit taken [DL];
        int best;
        int slot;
        if (rst_i) begin
            for (int s = 0; s <= S; s++) mv[s] = 1'b0;
        end else begin
            madv = bus.out_ready_i || !mv[S];
            if (bus.flush_i) begin
                for (int s = 0; s <= S; s++) mv[s] = 1'b0;
            end else if (madv) begin
                for (int s = S; s > 0; s--) begin
                    mv[s]  = mv[s-1];
                    mid[s] = mid[s-1];
                end
                mv[0] = bus.in_valid_i;
                if (bus.in_valid_i) begin
                    slot   = nvec % 1024;
                    mid[0] = slot;
                    for (int j = 0; j < DL; j++) taken[j] = 1'b0;
                    for (int r = 0; r < TK; r++) begin
                        best = -1;
                        for (int j = 0; j < DL; j++)
                            if (!taken[j] && (best < 0 ||
                                ranks_before(bus.x_i[j], j, bus.x_i[best], best, bus.desc_i)))
                                best = j;
                        taken[best] = 1'b1;
                        ey[slot][r] = bus.x_i[best];
                        ei[slot][r] = best;
                    end
                    nvec++;
                end
            end
        end
    end

    always @(negedge clk_i) begin : compare
        int cnt;
        cnt = 0;
        for (int s = 1; s <= S; s++) cnt += mv[s];
        check("out_valid", bus.out_valid_o, mv[S]);
        check("inflight", bus.inflight_o, cnt);
        check("in_ready", bus.in_ready_o, bus.out_ready_i || !mv[S]);
        if (mv[S])
            for (int k = 0; k < TK; k++) begin
                check("y_rank", bus.y_o[k], ey[mid[S]][k]);
                check("idx_rank", bus.idx_o[k], ei[mid[S]][k]);
            end
    end

    task automatic rand_vec();
        for (int j = 0; j < DL; j++) bus.x_i[j] = 8'($urandom_range(0, 31));
    endtask

    // mode 0: x[i]=i, 1: all 7, 2: {5,9,9,5,0...}
    task automatic directed(input int mode, input bit d,
                            input int y0, input int y1, input int y2, input int y3,
                            input int i0, input int i1, input int i2, input int i3);
        int n;
        int ye [4];
        int ie [4];
        ye[0] = y0; ye[1] = y1; ye[2] = y2; ye[3] = y3;
        ie[0] = i0; ie[1] = i1; ie[2] = i2; ie[3] = i3;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        repeat (S + 2) @(posedge clk_i);
        #1;
        bus.in_valid_i = 1'b1;
        bus.desc_i     = d;
        for (int j = 0; j < DL; j++)
            bus.x_i[j] = (mode == 0) ? 8'(j) : (mode == 1) ? 8'd7 :
                         (j == 1 || j == 2) ? 8'd9 : (j == 0 || j == 3) ? 8'd5 : 8'd0;
        @(posedge clk_i);
        #1;
        bus.in_valid_i = 1'b0;
        n = 0;
        while (!bus.out_valid_o && n < 40) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        check("latency", n, S);
        for (int k = 0; k < TK; k++) begin
            check("dir_y", bus.y_o[k], ye[k]);
            check("dir_idx", bus.idx_o[k], ie[k]);
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int first, last, cntv;
        logic [DW-1:0] snap [TK];
        bus.flush_i     = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.desc_i      = 1'b0;
        bus.out_ready_i = 1'b1;
        for (int j = 0; j < DL; j++) bus.x_i[j] = '0;
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_out_valid", bus.out_valid_o, 0);
        check("rst_inflight", bus.inflight_o, 0);
        check("rst_y0", bus.y_o[0], 0);
        rst_i = 1'b0;

        directed(0, 1'b1, 15, 14, 13, 12, 15, 14, 13, 12);
        directed(0, 1'b0, 0, 1, 2, 3, 0, 1, 2, 3);
        directed(1, 1'b1, 7, 7, 7, 7, 0, 1, 2, 3);
        directed(1, 1'b0, 7, 7, 7, 7, 0, 1, 2, 3);
        directed(2, 1'b1, 9, 9, 5, 5, 1, 2, 0, 3);

        // Back-to-back stream with alternating direction.
        repeat (S + 2) @(posedge clk_i);
        #1;
        bus.in_valid_i = 1'b1;
        bus.desc_i     = 1'b0;
        rand_vec();
        first = -1; last = -1; cntv = 0;
        for (int t = 0; t < 32; t++) begin
            @(posedge clk_i);
            #1;
            if (bus.out_valid_o) begin
                if (first < 0) first = t;
                last = t;
                cntv++;
            end
            if (t + 1 < 20) begin
                bus.desc_i = ~bus.desc_i;
                rand_vec();
            end else
                bus.in_valid_i = 1'b0;
        end
        check("tput_first", first, S);
        check("tput_last", last, S + 19);
        check("tput_count", cntv, 20);

        // Backpressure: consumer stalls for 5 edges mid-stream.
        bus.in_valid_i = 1'b1;
        rand_vec();
        for (int t = 0; t < 40; t++) begin
            @(posedge clk_i);
            #1;
            check("inflight_max", bus.inflight_o <= S, 1);
            if (t == 15) begin
                check("stall_valid", bus.out_valid_o, 1);
                for (int k = 0; k < TK; k++) snap[k] = bus.y_o[k];
                bus.out_ready_i = 1'b0;
            end else if (t > 15 && t <= 20) begin
                check("stall_in_ready", bus.in_ready_o, 0);
                for (int k = 0; k < TK; k++) check("stall_stable", bus.y_o[k], snap[k]);
                if (t == 20) bus.out_ready_i = 1'b1;
            end
            bus.in_valid_i = (t < 10) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
            bus.desc_i     = 1'($urandom);
            rand_vec();
        end
        bus.in_valid_i = 1'b0;
        repeat (S + 4) @(posedge clk_i);

        // Flush with 6 vectors in flight and a vector offered alongside.
        #1;
        bus.in_valid_i = 1'b1;
        for (int v = 0; v < 6; v++) begin
            rand_vec();
            @(posedge clk_i);
            #1;
        end
        bus.flush_i = 1'b1;
        rand_vec();
        @(posedge clk_i);
        #1;
        bus.flush_i    = 1'b0;
        bus.in_valid_i = 1'b0;
        check("flush_valid", bus.out_valid_o, 0);
        check("flush_inflight", bus.inflight_o, 0);
        directed(0, 1'b1, 15, 14, 13, 12, 15, 14, 13, 12);

        // Asynchronous reset between edges with results on the output.
        #1;
        bus.in_valid_i = 1'b1;
        for (int v = 0; v < 12; v++) begin
            rand_vec();
            bus.desc_i = 1'($urandom);
            @(posedge clk_i);
            #1;
        end
        #2;
        rst_i = 1'b1;
        #1;
        check("arst_valid", bus.out_valid_o, 0);
        check("arst_inflight", bus.inflight_o, 0);
        for (int k = 0; k < TK; k++) begin
            check("arst_y", bus.y_o[k], 0);
            check("arst_idx", bus.idx_o[k], 0);
        end
        bus.in_valid_i = 1'b0;
        @(posedge clk_i);
        #4;
        rst_i = 1'b0;
        directed(0, 1'b0, 0, 1, 2, 3, 0, 1, 2, 3);

        repeat (3) @(posedge clk_i);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bitonic_topk_stream.md
# bitonic_topk_stream

Parametrised, fully pipelined bitonic sorter with top-K selection and streaming handshake. Generalises the fixed 8-input sorter to any power-of-two DATALENGTH. Adds:
- a per-vector sort direction,
- a deterministic index tie-break,
- valid/ready backpressure, flush and an occupancy count.

Sits between the score generator and the top-K consumer. Accepts one vector per cycle and emits the TOPK best elements with their original lane indices.

## Interface
- DATAWIDTH, 8: unsigned element width.
- DATALENGTH, 16: elements per vector; power of two, ≥ 2.
- TOPK, 4: elements emitted per vector, 1..DATALENGTH.
- Derived L = log2(DATALENGTH); S = L*(L+1)/2 pipeline stages (16 → 10); IW = max(L,1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. One clock; reset is asynchronous and active-high.
- flush_i  in  1  synchronous clear of all in-flight vectors.
- in_valid_i  in  1  input vector valid.
- in_ready_o  out  1  block can accept.
- desc_i  in  1  1 = descending (largest first), 0 = ascending; sampled with the vector.
- x_i  in  DATAWIDTH × DATALENGTH  unpacked input lanes; lane i has index i.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts.
- y_o  out  DATAWIDTH × TOPK  sorted values; y_o[0] is rank 0 (best).
- idx_o  out  IW × TOPK  original lane index of each y_o entry.
- inflight_o  out  $clog2(S+1)  count of valid pipeline stages.

## Operation
- Each lane carries {value, index, desc}; the index is attached at input.
- Total order (ranking) per vector:
  - desc=1: larger value ranks first.
  - desc=0: smaller value ranks first.
  - Equal values: lower index ranks first, in both modes.
- The output is therefore unique for any input.
- Network: standard bitonic merge network, L merge phases, S compare-exchange columns. Each column is registered, together with its valid bit and the vector's desc bit.
- Compare-exchange uses the full (value, index) key. Direction of each comparator is derived from the stage/lane position and the vector's desc bit. Adjacent stages may hold vectors of opposite direction.
- Output: ranks 0..TOPK-1 of the final column. Remaining lanes are discarded.
- Values are unsigned, with no arithmetic, so no widening is needed.
- Flow control uses a global advance signal: adv = out_ready_i | ~out_valid_o.
  - All stages shift only when adv = 1.
  - in_ready_o = adv (combinational from out_ready_i and state).
  - Bubbles are not squeezed: an empty stage still costs a cycle.
- Accept: in_valid_i & in_ready_o at the clock edge; the vector is captured into stage 0.
- inflight_o = population count of stage valid bits. It is updated every cycle, including when adv = 0.
- flush_i = 1:
  - Clears all valid bits on the next edge; out_valid_o = 0 the following cycle.
  - A vector presented in the same cycle is dropped.
  - in_ready_o is unaffected.
- Reset (any time, including mid-stream):
  - Asynchronously clears all valid bits and data/index/desc registers.
  - out_valid_o = 0, y_o = 0, idx_o = 0, inflight_o = 0.
  - In-flight vectors are lost.
- Simultaneous flush and acceptance: flush wins. Simultaneous reset and anything: reset wins.

## Timing
- Latency: a vector accepted at edge k appears on out_valid_o/y_o/idx_o after edge k+S, provided adv = 1 throughout. Each cycle of adv = 0 adds one cycle.
- Throughput: one vector per cycle when out_ready_i = 1.
- While out_valid_o & ~out_ready_i:
  - All stages hold.
  - Outputs are stable.
  - in_ready_o = 0.
- Outputs are registered; only in_ready_o is combinational.

## Test plan
- Ordering/latency: defaults, x_i[i]=i, desc=1 → exactly S=10 cycles after acceptance, y_o = {15,14,13,12}, idx_o = {15,14,13,12}. Same with desc=0 → y_o = {0,1,2,3}, idx_o = {0,1,2,3}.
- Ties: all lanes = 7 → y_o = {7,7,7,7}, idx_o = {0,1,2,3}, for both desc values. Lanes {5,9,9,5,…rest 0}, desc=1 → y_o = {9,9,5,5}, idx_o = {1,2,0,3}.
- Throughput with alternating desc: 20 back-to-back random vectors, desc toggling, out_ready_i = 1 → 20 results on consecutive cycles 10..29, each matching the reference model.
- Backpressure: stream random vectors, out_ready_i held low for 5 cycles mid-run → no loss or duplication; in_ready_o = 0 and outputs stable while stalled; inflight_o ≤ 10.
- Flush: 6 vectors in flight, assert flush_i with in_valid_i = 1 → out_valid_o = 0 and inflight_o = 0 next cycle; the next accepted vector emerges 10 cycles later.
- Reset mid-stream: assert rst_i asynchronously between edges with vectors in flight → all outputs 0 immediately; after release, the first new vector has latency 10.
